// File: rtl/lzss_compress.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lzss_compress : byte-serial LZSS encoder (literal / MARKER,len,off tokens)  |
// | Optional: LZSS_COMPRESS_STATS_EN adds stat_in_bytes / stat_out_bytes.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module lzss_compress #(
  parameter logic [7:0] MARKER    = 8'h7E,
  parameter int         WIN_DEPTH = 255,
  parameter int         MAX_LEN   = 16,
  parameter int         MIN_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
`ifdef LZSS_COMPRESS_STATS_EN
  output logic        busy,
  output logic [31:0] stat_in_bytes,
  output logic [31:0] stat_out_bytes
`else
  output logic        busy
`endif
);

  localparam int         LW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] c_win = 8'(WIN_DEPTH);
  localparam logic [7:0] c_max = 8'(MAX_LEN);
  localparam logic [7:0] c_min = 8'(MIN_LEN);

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_FILL   = 3'd1,
    S_SEARCH = 3'd2,
    S_EMIT   = 3'd3,
    S_SEND   = 3'd4,
    S_SHIFT  = 3'd5
  } state_t;

  state_t     r_state;
  logic [7:0] r_hist [0:255];
  logic [7:0] r_la   [0:MAX_LEN-1];
  logic [7:0] r_wr_ptr, r_hist_cnt, r_la_cnt;
  logic       r_last_seen, r_final;
  logic [7:0] r_off, r_k, r_best_len, r_best_off, r_cons, r_b1, r_b2;
  logic [1:0] r_nbeats, r_beat;

  logic       w_in_fire, w_out_fire, w_eq, w_tok, w_fin;
  logic [7:0] w_omax, w_lim, w_hidx, w_cons;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_omax     = (r_hist_cnt < c_win) ? r_hist_cnt : c_win;
  assign w_lim      = (r_off < r_la_cnt) ? r_off : r_la_cnt;
  assign w_hidx     = r_wr_ptr - r_off + r_k;
  assign w_eq       = (r_k < w_lim) && (r_hist[w_hidx] == r_la[r_k[LW-1:0]]);
  assign w_tok      = (r_best_len >= c_min);
  assign w_cons     = w_tok ? r_best_len : 8'd1;
  assign w_fin      = r_last_seen && (r_la_cnt == w_cons);

  // Storage arrays carry no reset; validity is tracked by the counters below.
  always_ff @(posedge clk) begin
    if (r_state == S_SHIFT) begin
      r_hist[r_wr_ptr] <= r_la[0];
      for (int i = 0; i < MAX_LEN - 1; i++) r_la[i] <= r_la[i+1];
    end else if (r_state == S_FILL && w_in_fire) begin
      r_la[r_la_cnt[LW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HDR;
      r_wr_ptr    <= '0;
      r_hist_cnt  <= '0;
      r_la_cnt    <= '0;
      r_last_seen <= 1'b0;
      r_final     <= 1'b0;
      r_off       <= '0;
      r_k         <= '0;
      r_best_len  <= '0;
      r_best_off  <= '0;
      r_cons      <= '0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_nbeats    <= '0;
      r_beat      <= '0;
      in_ready    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        S_HDR: begin
          if (!out_valid) begin
            out_data  <= MARKER;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_in_fire) begin
            r_la_cnt <= r_la_cnt + 8'd1;
            busy     <= 1'b1;
            if (in_last) r_last_seen <= 1'b1;
            if (in_last || (r_la_cnt + 8'd1 == c_max)) begin
              in_ready   <= 1'b0;
              r_state    <= S_SEARCH;
              r_off      <= 8'd1;
              r_k        <= '0;
              r_best_len <= '0;
              r_best_off <= '0;
            end
          end
        end
        S_SEARCH: begin
          if (w_omax == 8'd0) begin
            r_state <= S_EMIT;
          end else if (w_eq) begin
            r_k <= r_k + 8'd1;
          end else begin
            if (r_k > r_best_len) begin
              r_best_len <= r_k;
              r_best_off <= r_off;
            end
            // r_k can only equal the lookahead count when the match is maximal.
            if (r_k == r_la_cnt || r_off == w_omax) begin
              r_state <= S_EMIT;
            end else begin
              r_off <= r_off + 8'd1;
              r_k   <= '0;
            end
          end
        end
        S_EMIT: begin
          r_cons    <= w_cons;
          r_final   <= w_fin;
          r_beat    <= '0;
          out_valid <= 1'b1;
          r_state   <= S_SEND;
          if (w_tok || r_la[0] == MARKER) begin
            out_data <= MARKER;
            r_b1     <= w_tok ? r_best_len : 8'd0;
            r_b2     <= w_tok ? r_best_off : 8'd0;
            r_nbeats <= 2'd3;
            out_last <= 1'b0;
          end else begin
            out_data <= r_la[0];
            r_nbeats <= 2'd1;
            out_last <= w_fin;
          end
        end
        S_SEND: begin
          if (w_out_fire) begin
            if (r_beat + 2'd1 == r_nbeats) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (out_last) busy <= 1'b0;
              r_state   <= S_SHIFT;
            end else begin
              r_beat   <= r_beat + 2'd1;
              out_data <= (r_beat == 2'd0) ? r_b1 : r_b2;
              out_last <= r_final && (r_beat == 2'd1);
            end
          end
        end
        S_SHIFT: begin
          r_wr_ptr <= r_wr_ptr + 8'd1;
          if (r_hist_cnt != 8'hFF) r_hist_cnt <= r_hist_cnt + 8'd1;
          r_la_cnt <= r_la_cnt - 8'd1;
          r_cons   <= r_cons - 8'd1;
          if (r_cons == 8'd1) begin
            if (!r_last_seen) begin
              in_ready <= 1'b1;
              r_state  <= S_FILL;
            end else if (r_la_cnt != 8'd1) begin
              r_state    <= S_SEARCH;
              r_off      <= 8'd1;
              r_k        <= '0;
              r_best_len <= '0;
              r_best_off <= '0;
            end else begin
              r_wr_ptr    <= '0;
              r_hist_cnt  <= '0;
              r_last_seen <= 1'b0;
              r_state     <= S_HDR;
            end
          end
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

`ifdef LZSS_COMPRESS_STATS_EN
  // Counters restart on a stream's first input so the previous totals stay
  // readable; the already-sent header is credited at that restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_in_bytes  <= '0;
      stat_out_bytes <= '0;
    end else if (w_in_fire && !busy) begin
      stat_in_bytes  <= 32'd1;
      stat_out_bytes <= 32'd1;
    end else begin
      if (w_in_fire) stat_in_bytes <= stat_in_bytes + 32'd1;
      if (w_out_fire && r_state != S_HDR) stat_out_bytes <= stat_out_bytes + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lzss_compress.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lzss_compress : randomized bench with a greedy LZSS reference model.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_lzss_compress;

  localparam logic [7:0] c_marker = 8'h7E;
  localparam int         c_budget = 40000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       busy;

  lzss_compress dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         in_acc = 0;
  int         last_idx = -1;
  int         last_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Greedy reference: longest match within min(255, bytes seen) offsets,
  // length limited by offset and by min(16, bytes remaining); first best wins.
  task automatic build_expected();
    int p, n, la, hc, bl, bo, len, lim;
    exp_q.delete();
    exp_q.push_back(c_marker);
    n = stim_q.size();
    p = 0;
    while (p < n) begin
      la = (n - p < 16) ? n - p : 16;
      hc = (p < 255) ? p : 255;
      bl = 0;
      bo = 0;
      for (int o = 1; o <= hc; o++) begin
        lim = (o < la) ? o : la;
        len = 0;
        while (len < lim && stim_q[p - o + len] == stim_q[p + len]) len++;
        if (len > bl) begin
          bl = len;
          bo = o;
        end
      end
      if (bl >= 4) begin
        exp_q.push_back(c_marker);
        exp_q.push_back(8'(bl));
        exp_q.push_back(8'(bo));
        p += bl;
      end else begin
        if (stim_q[p] == c_marker) begin
          exp_q.push_back(c_marker);
          exp_q.push_back(8'h00);
          exp_q.push_back(8'h00);
        end else begin
          exp_q.push_back(stim_q[p]);
        end
        p++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid) check("in_ready_outside_fill", in_ready, 0);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (out_last) begin
          if (last_idx < 0) last_idx = got_q.size() - 1;
          last_cnt++;
        end
      end
      if (in_valid && in_ready) in_acc++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // rmode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  task automatic run_stream(input int rmode, input int abort_after);
    int   cyc;
    logic done;
    @(posedge clk);
    #1;
    got_q.delete();
    in_acc   = 0;
    last_idx = -1;
    last_cnt = 0;
    cyc      = 0;
    done     = 1'b0;
    while (!done && cyc < c_budget) begin
      if (in_acc < stim_q.size()) begin
        in_valid = 1'b1;
        in_data  = stim_q[in_acc];
        in_last  = (in_acc == stim_q.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      case (rmode)
        1:       out_ready = (cyc % 3 == 0);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      cyc++;
      @(posedge clk);
      #1;
      if (abort_after > 0 && got_q.size() >= abort_after) break;
      done = (last_idx >= 0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    if (abort_after == 0) begin
      check("stream_timeout", done, 1);
      check("busy_after_last", busy, 0);
    end
  endtask

  task automatic run_and_check(input int rmode);
    build_expected();
    run_stream(rmode, 0);
    check("out_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("out_byte", got_q[i], exp_q[i]);
    check("last_index", last_idx, exp_q.size() - 1);
    check("last_count", last_cnt, 1);
  endtask

  initial begin
    logic [7:0] alpha[4];
    logic [7:0] pat[5];
    int         n;
    alpha[0] = 8'h41; alpha[1] = 8'h42; alpha[2] = 8'h7E; alpha[3] = 8'h43;
    pat[0] = 8'h10; pat[1] = 8'h20; pat[2] = 8'h30; pat[3] = 8'h7E; pat[4] = 8'h50;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("hdr_valid", out_valid, 1);
    check("hdr_data", out_data, c_marker);

    stim_q = {8'h41, 8'h42, 8'h43, 8'h44};
    run_and_check(0);
    stim_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h41, 8'h42, 8'h43, 8'h44};
    run_and_check(0);
    stim_q = {8'h7E};
    run_and_check(0);
    stim_q = {8'h41, 8'h42, 8'h41, 8'h42};
    run_and_check(0);
    stim_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h41, 8'h42, 8'h43, 8'h44};
    run_and_check(1);

    for (int s = 0; s < 8; s++) begin
      stim_q.delete();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) stim_q.push_back(alpha[$urandom_range(0, 3)]);
      run_and_check(2);
    end

    // Long periodic stream with sparse corruption: window wrap and long tokens.
    stim_q.delete();
    for (int i = 0; i < 270; i++)
      stim_q.push_back(($urandom_range(0, 24) == 0) ? 8'($urandom_range(0, 255)) : pat[i % 5]);
    run_and_check(2);

    // Asynchronous reset while the 8-byte stream is searching for its token.
    stim_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h41, 8'h42, 8'h43, 8'h44};
    run_stream(0, 5);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_last", out_last, 0);
    check("arst_out_data", out_data, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    stim_q = {8'h41, 8'h42, 8'h43, 8'h44};
    run_and_check(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
